game_controller: RTL and testbench

Top-level game sequencer for the bomb-squad design. Tracks player authentication, the countdown timer, strikes and the defuse/explode outcome. Drives the 8-bit `state` code consumed by the LED animation driver and other display stages. Only block allowed to change the game state.

---
 rtl/game_controller.sv | 169 ++++++++++++++++
 tb/tb_game_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller: top-level bomb-squad sequencer. It owns the game state code
// and tracks authentication failures, the countdown timer and strikes, and
// decides between the defuse and explode outcomes. All outputs are registered.
module game_controller #(
  parameter int TICK_CYCLES  = 50_000_000,  // clock cycles per countdown second
  parameter int GAME_SECONDS = 60,          // timer load value (1..255)
  parameter int SEQ_CYCLES   = 50_000_000,  // dwell of the timed display states
  parameter int MAX_FAILS    = 3,           // consecutive auth failures to lose (1..3)
  parameter int MAX_STRIKES  = 3            // strikes to lose (1..3)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       auth_valid,
  input  logic       auth_ok,
  input  logic       defused,
  input  logic       strike,
  input  logic       start,
  output logic [7:0] state,
  output logic [7:0] seconds_left,
  output logic [1:0] strikes,
  output logic [1:0] fails
);

  // State codes double as the display code seen by downstream stages.
  typedef enum logic [7:0] {
    AUTH      = 8'h00,
    AUTH_OK   = 8'h01,
    AUTH_FAIL = 8'h02,
    GAME      = 8'h10,
    WIN_SEQ   = 8'h20,
    WIN_END   = 8'h21,
    LOSE_SEQ  = 8'h30,
    LOSE_END  = 8'h31
  } state_t;

  // The +1 keeps each counter at least one bit wide when the count is 1.
  localparam int TICK_W  = $clog2(TICK_CYCLES + 1);
  localparam int DWELL_W = $clog2(SEQ_CYCLES + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEQ_CYCLES - 1);
  localparam logic [7:0]         SECS_LOAD  = 8'(GAME_SECONDS);
  localparam logic [1:0]         FAIL_LIMIT = 2'(MAX_FAILS);
  localparam logic [1:0]         STRK_LIMIT = 2'(MAX_STRIKES);

  state_t               state_q, state_d;
  logic [7:0]           secs_q, secs_d;
  logic [1:0]           strikes_q, strikes_d;
  logic [1:0]           fails_q, fails_d;
  logic [TICK_W-1:0]    presc_q, presc_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;

  logic                 tick;
  logic                 dwell_done;
  logic [1:0]           fails_inc;
  logic [1:0]           strikes_inc;

  assign tick        = (presc_q == TICK_LAST);
  assign dwell_done  = (dwell_q == DWELL_LAST);
  assign fails_inc   = (fails_q == 2'd3) ? 2'd3 : fails_q + 2'd1;
  assign strikes_inc = (strikes_q == 2'd3) ? 2'd3 : strikes_q + 2'd1;

  // Next-state and next-counter logic for every state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    secs_d    = secs_q;
    strikes_d = strikes_q;
    fails_d   = fails_q;
    // Both counters idle at zero, so any state entry starts them from zero.
    presc_d   = '0;
    dwell_d   = '0;

    case (state_q)
      AUTH: begin
        if (auth_valid) begin
          if (auth_ok) begin
            state_d = AUTH_OK;
            fails_d = 2'd0;
          end else begin
            fails_d = fails_inc;
            state_d = (fails_inc == FAIL_LIMIT) ? LOSE_SEQ : AUTH_FAIL;
          end
        end
      end

      AUTH_OK: begin
        if (dwell_done) begin
          state_d   = GAME;
          secs_d    = SECS_LOAD;
          strikes_d = 2'd0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      AUTH_FAIL: begin
        if (dwell_done) state_d = AUTH;
        else            dwell_d = dwell_q + 1'b1;
      end

      GAME: begin
        if (defused) begin
          // Defuse wins over everything and freezes both counters.
          state_d = WIN_SEQ;
        end else begin
          if (strike) begin
            strikes_d = strikes_inc;
            if (strikes_inc == STRK_LIMIT) state_d = LOSE_SEQ;
          end
          if (tick) begin
            if (secs_q != 8'd0) secs_d = secs_q - 8'd1;
            if (secs_q == 8'd1) state_d = LOSE_SEQ;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      WIN_SEQ: begin
        if (dwell_done) state_d = WIN_END;
        else            dwell_d = dwell_q + 1'b1;
      end

      LOSE_SEQ: begin
        if (dwell_done) state_d = LOSE_END;
        else            dwell_d = dwell_q + 1'b1;
      end

      WIN_END, LOSE_END: begin
        if (start) begin
          state_d = AUTH;
          fails_d = 2'd0;
        end
      end

      // Any code outside the legal set recovers to authentication.
      default: state_d = AUTH;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!reset) begin
      state_q   <= AUTH;
      secs_q    <= SECS_LOAD;
      strikes_q <= 2'd0;
      fails_q   <= 2'd0;
      presc_q   <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      strikes_q <= strikes_d;
      fails_q   <= fails_d;
      presc_q   <= presc_d;
      dwell_q   <= dwell_d;
    end
  end

  assign state        = state_q;
  assign seconds_left = secs_q;
  assign strikes      = strikes_q;
  assign fails        = fails_q;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed table of per-edge vectors for authentication,
// dwell and timeout behaviour, followed by hand-written multi-cycle sequences
// for the strike limit, defuse priority and mid-game reset.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       auth_valid = 1'b0;
  logic       auth_ok = 1'b0;
  logic       defused = 1'b0;
  logic       strike = 1'b0;
  logic       start = 1'b0;
  logic [7:0] state;
  logic [7:0] seconds_left;
  logic [1:0] strikes;
  logic [1:0] fails;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  game_controller #(
    .TICK_CYCLES (4),
    .GAME_SECONDS(3),
    .SEQ_CYCLES  (5),
    .MAX_FAILS   (3),
    .MAX_STRIKES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .auth_valid  (auth_valid),
    .auth_ok     (auth_ok),
    .defused     (defused),
    .strike      (strike),
    .start       (start),
    .state       (state),
    .seconds_left(seconds_left),
    .strikes     (strikes),
    .fails       (fails)
  );

  // One row per clock edge: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic       rst, av, ok, df, sk, st;
    logic [7:0] e_state;
    logic [7:0] e_secs;
    logic [1:0] e_strikes;
    logic [1:0] e_fails;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int rst, input int av, input int ok, input int df,
                              input int sk, input int st, input int es, input int secs,
                              input int stk, input int fl);
    vec_t v;
    v.rst = rst[0]; v.av = av[0]; v.ok = ok[0]; v.df = df[0]; v.sk = sk[0]; v.st = st[0];
    v.e_state = es[7:0]; v.e_secs = secs[7:0]; v.e_strikes = stk[1:0]; v.e_fails = fl[1:0];
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] actual, input int expected);
    n_checks++;
    if (actual !== expected[7:0]) begin
      n_fails++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected[7:0]);
    end
  endtask

  task automatic check_all(input string tag, input int es, input int secs,
                           input int stk, input int fl);
    check({tag, " state"}, state, es);
    check({tag, " seconds_left"}, seconds_left, secs);
    check({tag, " strikes"}, {6'd0, strikes}, stk);
    check({tag, " fails"}, {6'd0, fails}, fl);
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic step(input int rst, input int av, input int ok, input int df,
                      input int sk, input int st);
    @(negedge clk);
    reset = rst[0]; auth_valid = av[0]; auth_ok = ok[0];
    defused = df[0]; strike = sk[0]; start = st[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // Successful authentication followed by the full AUTH_OK dwell into GAME.
  task automatic auth_to_game(input string tag);
    step(1, 1, 1, 0, 0, 0);
    check({tag, " auth_ok entry"}, state, 8'h01);
    idle(4);
    check({tag, " auth_ok dwell"}, state, 8'h01);
    idle(1);
    check_all({tag, " game entry"}, 8'h10, 3, 0, 0);
  endtask

  initial begin
    // Reset, then three failed attempts ending in LOSE and a restart.
    add(0,0,0,0,0,0, 8'h00,3,0,0);
    add(1,1,0,0,0,0, 8'h02,3,0,1);
    repeat (4) add(1,0,0,0,0,0, 8'h02,3,0,1);
    add(1,0,0,0,0,0, 8'h00,3,0,1);
    add(1,1,0,0,0,0, 8'h02,3,0,2);
    add(1,0,0,0,0,0, 8'h02,3,0,2);
    add(1,1,1,0,0,0, 8'h02,3,0,2);   // auth_valid ignored while dwelling
    repeat (2) add(1,0,0,0,0,0, 8'h02,3,0,2);
    add(1,0,0,0,0,0, 8'h00,3,0,2);
    add(1,1,0,0,0,0, 8'h30,3,0,3);   // third failure goes straight to LOSE_SEQ
    add(1,0,0,0,0,0, 8'h30,3,0,3);
    add(1,0,0,0,0,1, 8'h30,3,0,3);   // start ignored in LOSE_SEQ
    repeat (2) add(1,0,0,0,0,0, 8'h30,3,0,3);
    repeat (2) add(1,0,0,0,0,0, 8'h31,3,0,3);
    add(1,0,0,0,0,1, 8'h00,3,0,0);
    add(1,0,0,1,1,0, 8'h00,3,0,0);   // defused/strike ignored in AUTH
    // Successful authentication and AUTH_OK dwell.
    add(1,1,1,0,0,0, 8'h01,3,0,0);
    add(1,0,0,0,0,0, 8'h01,3,0,0);
    add(1,1,0,0,0,0, 8'h01,3,0,0);   // auth_valid ignored in AUTH_OK
    repeat (2) add(1,0,0,0,0,0, 8'h01,3,0,0);
    add(1,0,0,0,0,0, 8'h10,3,0,0);
    // Timeout: ticks at 4, 8 and 12 edges after entry.
    add(1,0,0,0,0,0, 8'h10,3,0,0);
    add(1,0,0,0,0,1, 8'h10,3,0,0);   // start ignored in GAME
    add(1,0,0,0,0,0, 8'h10,3,0,0);
    add(1,0,0,0,0,0, 8'h10,2,0,0);
    repeat (3) add(1,0,0,0,0,0, 8'h10,2,0,0);
    add(1,0,0,0,0,0, 8'h10,1,0,0);
    repeat (3) add(1,0,0,0,0,0, 8'h10,1,0,0);
    add(1,0,0,0,0,0, 8'h30,0,0,0);
    repeat (4) add(1,0,0,0,0,0, 8'h30,0,0,0);
    add(1,0,0,0,0,0, 8'h31,0,0,0);
    add(1,0,0,0,0,1, 8'h00,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].av, vecs[i].ok, vecs[i].df, vecs[i].sk, vecs[i].st);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_secs,
                vecs[i].e_strikes, vecs[i].e_fails);
    end

    // Strike limit: strike at edge 2 after entry, second strike lands on the first tick.
    auth_to_game("strk");
    idle(1);
    step(1, 0, 0, 0, 1, 0);
    check_all("strk first", 8'h10, 3, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 0);
    check_all("strk limit", 8'h30, 2, 2, 0);
    idle(4);
    check("strk lose dwell", state, 8'h30);
    idle(1);
    check("strk lose end", state, 8'h31);
    step(1, 0, 0, 0, 0, 1);
    check_all("strk restart", 8'h00, 2, 2, 0);

    // Defuse with a strike on the final-tick edge: defuse wins, counters frozen.
    auth_to_game("dfs");
    idle(11);
    check_all("dfs before", 8'h10, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    check_all("dfs win", 8'h20, 1, 0, 0);
    idle(4);
    check("dfs win dwell", state, 8'h20);
    idle(1);
    check("dfs win end", state, 8'h21);
    step(1, 0, 0, 0, 0, 1);
    check_all("dfs restart", 8'h00, 1, 0, 0);

    // Reset mid-game overrides a simultaneous defuse and strike.
    auth_to_game("rst");
    step(1, 0, 0, 0, 1, 0);
    idle(3);
    check_all("rst before", 8'h10, 2, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    check_all("rst game", 8'h00, 3, 0, 0);

    // Reset mid-dwell clears fails and the dwell counter.
    step(1, 1, 0, 0, 0, 0);
    check("rst fail entry", {6'd0, fails}, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0);
    check_all("rst dwell", 8'h00, 3, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check_all("rst refail", 8'h02, 3, 0, 1);
    idle(4);
    check("rst refail dwell", state, 8'h02);
    idle(1);
    check("rst refail done", state, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
